// File: rtl/uart_pkg.sv
// UART shared definitions: frame length, tx FSM states, default baud divisor.
// FRAME_BITS grows to 11 when UART_TX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam int BAUD_DIV_DEF = 868;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte holding FIFO for the UART transmitter.
// Pointers wrap naturally; count is one bit wider than the pointers.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          wr_en;
  logic          rd_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign dout  = mem[rd_ptr];

  // a pop in the same cycle frees the slot a full push needs
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-fed, start + 8 data (LSB first) + stop.
// Define UART_TX_PARITY_EN for an even/odd parity bit and parity_odd port.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  input  logic       clr_done,
`ifdef UART_TX_PARITY_EN
  input  logic       parity_odd,
`endif
  output logic       TX,
  output logic       tx_done,
  output logic       busy,
  output logic       full,
  output logic       ovf
);

  localparam int SR_W = FRAME_BITS;
  localparam logic [9:0] BAUD_MAX = 10'(BAUD_DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

  tx_state_t     state;
  logic [SR_W-1:0] shift_reg;
  logic [SR_W-1:0] load_val;
  logic [9:0]    baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    dout;
  logic          empty;
  logic          pop;
  logic          baud_wrap;
  logic          frame_end;
  logic          end_q;
  logic          ovf_set;

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (trmt),
    .din  (tx_data),
    .pop  (pop),
    .dout (dout),
    .empty(empty),
    .full (full)
  );

`ifdef UART_TX_PARITY_EN
  assign load_val = {1'b1, ^dout ^ parity_odd, dout, 1'b0};
`else
  assign load_val = {1'b1, dout, 1'b0};
`endif

  // last baud tick of the stop bit ends the frame
  assign baud_wrap = (state == SHIFT) && (baud_cnt == BAUD_MAX);
  assign frame_end = baud_wrap && (bit_cnt == BIT_LAST);
  assign pop = ~empty & ((state == IDLE) | frame_end);
  assign ovf_set = trmt & full & ~pop;

  // TX is registered, so the line stays busy through end_q
  assign busy = (state != IDLE) | ~empty | end_q;

  // frame FSM with baud and bit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
    end else if (pop) begin
      state     <= SHIFT;
      shift_reg <= load_val;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
    end else if (frame_end) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state == SHIFT) begin
      if (baud_wrap) begin
        baud_cnt  <= '0;
        shift_reg <= {1'b1, shift_reg[SR_W-1:1]};
        bit_cnt   <= bit_cnt + 4'd1;
      end else begin
        baud_cnt <= baud_cnt + 10'd1;
      end
    end
  end

  // serial line output register
  always_ff @(posedge clk) begin
    if (rst) TX <= 1'b1;
    else     TX <= (state == SHIFT) ? shift_reg[0] : 1'b1;
  end

  // sticky flags; a set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      end_q   <= 1'b0;
      tx_done <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      end_q <= frame_end;
      if (end_q)         tx_done <= 1'b1;
      else if (clr_done) tx_done <= 1'b0;
      if (ovf_set)       ovf <= 1'b1;
      else if (clr_done) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at BAUD_DIV=16, FIFO_DEPTH=4.
// A line monitor decodes TX frames and checks them against queued bytes.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int BD = 16;
  localparam int FB = FRAME_BITS;
  localparam int FP = FB * BD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trmt = 1'b0;
  logic       clr_done = 1'b0;
  logic [7:0] tx_data = 8'h00;
`ifdef UART_TX_PARITY_EN
  logic       parity_odd = 1'b0;
`endif
  logic       TX;
  logic       tx_done;
  logic       busy;
  logic       full;
  logic       ovf;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic [8:0] exp_q[$];
  int falls[$];

  uart_tx #(
    .BAUD_DIV  (BD),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .trmt    (trmt),
    .clr_done(clr_done),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .TX      (TX),
    .tx_done (tx_done),
    .busy    (busy),
    .full    (full),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b);
    tx_data = b;
    trmt = 1'b1;
    step();
  endtask

  task automatic expect_b(input logic par, input logic [7:0] b);
    exp_q.push_back({par, b});
  endtask

  task automatic pulse_clr();
    clr_done = 1'b1;
    step();
    clr_done = 1'b0;
  endtask

  task automatic wait_idle(output int t, input int bound, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    t = cyc;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: busy still 1 after %0d cycles", name, bound);
    end
  endtask

  task automatic wait_done(output int t, output int pb, input int bound, input string name);
    bit ok;
    ok = 1'b0;
    pb = busy;
    for (int i = 0; i < bound; i++) begin
      pb = busy;
      step();
      if (tx_done) begin
        ok = 1'b1;
        break;
      end
    end
    t = cyc;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: tx_done not seen within %0d cycles", name, bound);
    end
  endtask

  // line monitor: decode frames from TX, sampling mid-bit
  logic        tx_prev = 1'b1;
  bit          m_act = 1'b0;
  int          m_cnt = 0;
  logic [10:0] m_bits = '0;

  task automatic check_frame();
    logic [8:0] e;
    frames++;
    chk("start_bit", m_bits[0], 0);
    chk("stop_bit", m_bits[FB-1], 1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got data %02h expected none", m_bits[8:1]);
    end else begin
      e = exp_q.pop_front();
      chk("frame_data", int'(m_bits[8:1]), int'(e[7:0]));
`ifdef UART_TX_PARITY_EN
      chk("parity_bit", m_bits[9], e[8]);
`endif
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_act = 1'b0;
      tx_prev = 1'b1;
    end else begin
      if (!m_act) begin
        if (tx_prev && !TX) begin
          m_act = 1'b1;
          m_cnt = 0;
          m_bits = '0;
          falls.push_back(cyc);
        end
      end else begin
        m_cnt++;
        if (m_cnt % BD == BD / 2) begin
          m_bits[m_cnt / BD] = TX;
          if (m_cnt / BD == FB - 1) begin
            m_act = 1'b0;
            check_frame();
          end
        end
      end
      tx_prev = TX;
    end
  end

  initial begin
    int n;
    int t;
    int pb;
    int f0;
    logic [7:0] ov [6];

    ov[0] = 8'h11; ov[1] = 8'h22; ov[2] = 8'h33;
    ov[3] = 8'h44; ov[4] = 8'h55; ov[5] = 8'h66;

    // reset state
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_TX", TX, 1);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);

    // single byte 0xA5: latency, done timing, busy drop
    falls.delete();
    expect_b(1'b0, 8'hA5);
    drive(8'hA5);
    trmt = 1'b0;
    n = cyc;
    chk("busy_after_push", busy, 1);
    wait_done(t, pb, 3 * FP, "single_done");
    chk("single_done_time", t, n + 2 + FP);
    chk("single_busy_at_done", busy, 0);
    chk("single_busy_before", pb, 1);
    chk("single_fall_time", (falls.size() > 0) ? falls[0] : -1, n + 2);
    pulse_clr();
    chk("single_done_clr", tx_done, 0);

    // back-to-back frames with no idle gap
    falls.delete();
    expect_b(1'b0, 8'h00);
    expect_b(1'b0, 8'hFF);
    expect_b(1'b0, 8'h3C);
    drive(8'h00);
    n = cyc;
    drive(8'hFF);
    drive(8'h3C);
    trmt = 1'b0;
    wait_done(t, pb, 3 * FP, "b2b_first_done");
    chk("b2b_first_done", t, n + 2 + FP);
    wait_idle(t, 4 * FP, "b2b_idle");
    chk("b2b_total", t, n + 2 + 3 * FP);
    chk("b2b_falls", falls.size(), 3);
    if (falls.size() == 3) begin
      chk("b2b_start", falls[0], n + 2);
      chk("b2b_gap1", falls[1] - falls[0], FP);
      chk("b2b_gap2", falls[2] - falls[1], FP);
    end
    pulse_clr();

    // overflow: six pushes, five accepted
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) expect_b(1'b0, ov[i]);
      drive(ov[i]);
      if (i == 4) begin
        chk("ovf_fifth_full", full, 1);
        chk("ovf_fifth_ovf", ovf, 0);
      end
    end
    trmt = 1'b0;
    chk("ovf_set", ovf, 1);
    chk("ovf_full", full, 1);
    wait_idle(t, 7 * FP, "ovf_idle");
    chk("ovf_frames", frames - f0, 5);
    chk("ovf_sticky", ovf, 1);
    pulse_clr();
    chk("ovf_clr", ovf, 0);
    chk("ovf_done_clr", tx_done, 0);

    // push while full, coinciding with the frame-end pop
    f0 = frames;
    for (int i = 0; i < 6; i++) expect_b(1'b0, 8'hC1 + 8'(i));
    drive(8'hC1);
    n = cyc;
    for (int i = 1; i < 5; i++) drive(8'hC1 + 8'(i));
    trmt = 1'b0;
    while (cyc < n + FP) step();
    chk("fp_full_before", full, 1);
    drive(8'hC6);
    trmt = 1'b0;
    chk("fp_ovf", ovf, 0);
    chk("fp_full_after", full, 1);
    wait_idle(t, 7 * FP, "fp_idle");
    chk("fp_frames", frames - f0, 6);
    pulse_clr();

    // reset during data bit 3 with two bytes queued
    drive(8'h5A);
    n = cyc;
    drive(8'h5B);
    drive(8'h5C);
    trmt = 1'b0;
    while (cyc < n + 70) step();
    chk("mid_bit3", TX, 1);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    falls.delete();
    chk("mid_rst_TX", TX, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_full", full, 0);
    repeat (2 * FP) step();
    chk("mid_no_frames", falls.size(), 0);
    f0 = frames;
    expect_b(1'b0, 8'h81);
    drive(8'h81);
    trmt = 1'b0;
    wait_idle(t, 3 * FP, "post_rst_idle");
    chk("post_rst_frames", frames - f0, 1);

`ifdef UART_TX_PARITY_EN
    // parity: 0x07 even -> 1, odd -> 0, 176-clock frame
    pulse_clr();
    parity_odd = 1'b0;
    expect_b(1'b1, 8'h07);
    drive(8'h07);
    trmt = 1'b0;
    n = cyc;
    wait_done(t, pb, 3 * FP, "par_even_done");
    chk("par_frame_time", t, n + 2 + 176);
    wait_idle(t, FP, "par_even_idle");
    pulse_clr();
    parity_odd = 1'b1;
    expect_b(1'b0, 8'h07);
    drive(8'h07);
    trmt = 1'b0;
    wait_idle(t, 3 * FP, "par_odd_idle");
    parity_odd = 1'b0;
`endif

    repeat (4) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
